// File: rtl/pattern_scan_ctrl_if.sv
// Upstream word handshake plus scan status for pattern_scan_ctrl.
// master = word source / observer, slave = the controller.
interface pattern_scan_ctrl_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       busy;
  logic       det_pulse;
  logic [7:0] match_cnt;
  logic       done;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, busy, det_pulse,
    input  match_cnt, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, busy, det_pulse,
    output match_cnt, done
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial pattern scanner: shifts 8-bit words MSB first through a
// PAT_LEN-bit window and counts (overlapping) matches per frame.
module pattern_scan_ctrl #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011
) (
  input logic                clk,
  input logic                reset,
  pattern_scan_ctrl_if.slave bus
);

  localparam int FW = $clog2(PAT_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [7:0]         r_sr;
  logic [2:0]         r_idx;
  logic               r_last;
  logic               r_in_frame;
  logic [PAT_LEN-1:0] r_win;
  logic [FW-1:0]      r_fill;
  logic [7:0]         r_cnt;
  logic               r_det;

  logic               w_bit;
  logic [PAT_LEN-1:0] w_win_nxt;
  logic [FW-1:0]      w_fill_nxt;
  logic               w_match;
  logic [7:0]         w_cnt_inc;
  logic               w_ready;
  logic               w_hs;

  assign w_bit     = r_sr[7];
  assign w_win_nxt = {r_win[PAT_LEN-2:0], w_bit};

  assign w_fill_nxt =
    (r_fill == FW'(PAT_LEN)) ? r_fill : r_fill + FW'(1);

  // r_fill counts bits before this one, so PAT_LEN-1 means window full
  assign w_match =
    (w_win_nxt == PATTERN) &&
    (r_fill >= FW'(PAT_LEN - 1));

  assign w_cnt_inc =
    (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

  // gated by reset so in_ready is low while held in reset
  assign w_ready = reset & (
    (r_state == S_IDLE) |
    ((r_state == S_SHIFT) & (r_idx == 3'd0) & ~r_last)
  );

  assign w_hs = bus.in_valid & w_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_sr       <= '0;
      r_idx      <= '0;
      r_last     <= 1'b0;
      r_in_frame <= 1'b0;
      r_win      <= '0;
      r_fill     <= '0;
      r_cnt      <= '0;
      r_det      <= 1'b0;
    end else begin
      r_det <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_sr       <= bus.in_data;
            r_last     <= bus.in_last;
            r_idx      <= 3'd7;
            r_state    <= S_SHIFT;
            r_in_frame <= 1'b1;
            if (!r_in_frame) r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_win  <= w_win_nxt;
          r_fill <= w_fill_nxt;
          r_sr   <= {r_sr[6:0], 1'b0};
          r_idx  <= r_idx - 3'd1;
          if (w_match) begin
            r_det <= 1'b1;
            r_cnt <= w_cnt_inc;
          end
          if (r_idx == 3'd0) begin
            if (r_last) begin
              r_state <= S_DONE;
            end else if (w_hs) begin
              r_sr   <= bus.in_data;
              r_last <= bus.in_last;
              r_idx  <= 3'd7;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_win      <= '0;
          r_fill     <= '0;
          r_in_frame <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.det_pulse = r_det;
  assign bus.match_cnt = r_cnt;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl (PATTERN = 1011).
// Counts frame matches, pulses, handshake spacing and done timing.
module tb_pattern_scan_ctrl;

  logic clk;
  logic reset;

  pattern_scan_ctrl_if bus ();

  pattern_scan_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs;
  int errs;
  int cyc;
  int tot_pulses;
  int tot_hs;
  int last_pulse_cyc;
  int hs0;
  int hs1;
  int done_c;
  int p_base;
  int h_base;

  logic [7:0] words [0:127];

  initial begin
    cyc = 0;
    tot_hs = 0;
  end

  always @(posedge clk) begin
    if (reset && bus.in_valid && bus.in_ready)
      tot_hs = tot_hs + 1;
    cyc = cyc + 1;
  end

  initial begin
    tot_pulses = 0;
    last_pulse_cyc = -1;
  end

  always @(negedge clk) begin
    if (reset && bus.det_pulse) begin
      tot_pulses = tot_pulses + 1;
      last_pulse_cyc = cyc;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // hs edges are recorded as the cyc value of the accepting edge
  task automatic send_frame(
    input int n,
    input int gap,
    input bit noise
  );
    int t;
    p_base = tot_pulses;
    h_base = tot_hs;
    hs0 = -1;
    hs1 = -1;
    done_c = -1;
    for (int i = 0; i < n; i++) begin
      t = 0;
      @(negedge clk);
      while (!bus.in_ready && t < 40) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready) begin
        chk("ready_timeout", 0, 1);
        return;
      end
      if (i > 0 && gap > 0) repeat (gap) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = words[i];
      bus.in_last  = (i == n - 1);
      @(negedge clk);
      if (i == 0) hs0 = cyc - 1;
      if (i == 1) hs1 = cyc - 1;
      bus.in_valid = noise && (i == n - 1);
      bus.in_data  = 8'hFF;
      bus.in_last  = 1'b0;
      if (i == 0) chk("cnt_clear", bus.match_cnt, 0);
    end
    t = 0;
    while (!bus.done && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) begin
      bus.in_valid = 1'b0;
      chk("done_timeout", 0, 1);
      return;
    end
    done_c = cyc;
    chk("done_rdy", bus.in_ready, 0);
    chk("done_busy", bus.busy, 1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("done_1cyc", bus.done, 0);
    chk("idle_rdy", bus.in_ready, 1);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    #2;
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_det", bus.det_pulse, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.match_cnt, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ready", bus.in_ready, 1);
    chk("rel_busy", bus.busy, 0);

    // single word, one match
    words[0] = 8'b1011_0000;
    send_frame(1, 0, 1'b0);
    chk("w1_cnt", bus.match_cnt, 1);
    chk("w1_pulses", tot_pulses - p_base, 1);
    chk("w1_done_lat", done_c - hs0, 9);
    chk("w1_det_lat", last_pulse_cyc - hs0, 5);

    // overlapping matches; in_valid held while not ready
    words[0] = 8'b1011_0110;
    send_frame(1, 0, 1'b1);
    chk("ovl_cnt", bus.match_cnt, 2);
    chk("ovl_pulses", tot_pulses - p_base, 2);
    chk("ovl_hs", tot_hs - h_base, 1);

    // back-to-back words, match spans the boundary
    words[0] = 8'b0000_0101;
    words[1] = 8'b1000_0000;
    send_frame(2, 0, 1'b0);
    chk("b2b_cnt", bus.match_cnt, 1);
    chk("b2b_gap", hs1 - hs0, 8);
    chk("b2b_pulses", tot_pulses - p_base, 1);

    // mid-frame idle gap keeps count and window
    words[0] = 8'b1011_0000;
    words[1] = 8'b0000_0000;
    send_frame(2, 3, 1'b0);
    chk("gap_cnt", bus.match_cnt, 1);
    chk("gap_hs", hs1 - hs0, 11);
    repeat (3) @(negedge clk);
    chk("cnt_hold", bus.match_cnt, 1);

    // separate frames: window cleared between them
    words[0] = 8'b0000_0101;
    send_frame(1, 0, 1'b0);
    chk("frA_cnt", bus.match_cnt, 0);
    words[0] = 8'b1000_0000;
    send_frame(1, 0, 1'b0);
    chk("frB_cnt", bus.match_cnt, 0);
    chk("frB_pulses", tot_pulses - p_base, 0);

    // 128 words -> 256 matches, count saturates
    for (int i = 0; i < 128; i++) words[i] = 8'b1011_1011;
    send_frame(128, 0, 1'b0);
    chk("sat_cnt", bus.match_cnt, 255);
    chk("sat_pulses", tot_pulses - p_base, 256);

    // reset after 3 bits (window 101) of a frame
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'b1011_1011;
    bus.in_last  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", bus.busy, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_ready", bus.in_ready, 0);
    chk("mid_busy0", bus.busy, 0);
    chk("mid_det", bus.det_pulse, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_cnt", bus.match_cnt, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rel_rdy", bus.in_ready, 1);

    words[0] = 8'b1000_0000;
    send_frame(1, 0, 1'b0);
    chk("post_cnt0", bus.match_cnt, 0);
    words[0] = 8'b1011_0110;
    send_frame(1, 0, 1'b0);
    chk("post_cnt2", bus.match_cnt, 2);
    chk("post_pulses", tot_pulses - p_base, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 Parameter PAT_LEN, default 4, pattern length in bits (legal 2..8).
REQ-002 Parameter PATTERN, default 4'b1011, PAT_LEN-bit pattern to detect, MSB compared first.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_data  input  8  word to scan, serialized MSB first.
REQ-007 in_last  input  1  qualifies in_data as the final word of a frame.
REQ-008 in_ready  output  1  controller can accept a word this cycle.
REQ-009 busy  output  1  high in SHIFT or DONE.
REQ-010 det_pulse  output  1  one-cycle pulse per pattern match.
REQ-011 match_cnt  output  8  matches in current/last frame, saturating.
REQ-012 done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; handshake = in_valid & in_ready on a rising edge.
REQ-014 IDLE: in_ready=1; on handshake, load in_data to shift register, latch in_last, bit index=7, go SHIFT.
REQ-015 SHIFT: one bit per cycle, MSB first, into PAT_LEN-bit window {window[PAT_LEN-2:0], bit}; 8 cycles per word.
REQ-016 SHIFT: in_ready=1 only in the cycle shifting bit 0, when latched last=0; handshake then loads the next word, stays in SHIFT, no gap cycle.
REQ-017 After bit 0: latched last=1 -> DONE; last=0 and no handshake -> IDLE.
REQ-018 DONE lasts exactly one cycle: done=1, in_ready=0, then IDLE.
REQ-019 Match = next-window equals PATTERN and at least PAT_LEN bits shifted since frame start; overlapping matches all count.
REQ-020 Window and bit-fill count persist across words of a frame (matches span word boundaries); both clear on leaving DONE.
REQ-021 match_cnt increments on the edge that shifts the completing bit; saturates at 255, never wraps.
REQ-022 match_cnt clears on the handshake accepting the first word of a new frame; otherwise holds (readable after done).
REQ-023 det_pulse registered: high exactly the cycle after the edge that shifted the completing bit (may coincide with done).
REQ-024 in_valid while in_ready=0 is ignored; in_data/in_last sampled only on handshake.

Reset
REQ-025 reset=0 asynchronously forces: state IDLE, window/fill count/shift register cleared, match_cnt=0, det_pulse=0, done=0, busy=0, in_ready=0.
REQ-026 First cycle after reset release: in_ready=1; reset mid-frame discards the frame and any pending match.

Verification
REQ-027 One word 8'b1011_0000, in_last=1 -> det_pulse once (cycle after 4th bit), done 9 cycles after handshake, match_cnt=1.
REQ-028 One word 8'b1011_0110, in_last=1 -> two det_pulses (overlapping), match_cnt=2.
REQ-029 Frame 8'b0000_0101 (last=0) then 8'b1000_0000 (last=1) back-to-back -> second handshake in bit-0 cycle, no gap; match_cnt=1 (cross-word match).
REQ-030 Frame A 8'b0000_0101 last=1, then frame B 8'b1000_0000 last=1 -> match_cnt=0 for both (window cleared between frames).
REQ-031 Frame of 128 words 8'b1011_1011 -> 256 matches, match_cnt=255 at done, no wrap.
REQ-032 reset=0 mid-SHIFT -> all outputs 0 immediately (no clock edge); after release in_ready=1, new frame scans correctly from cleared window.
